// File: rtl/scan_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : scan_pkg                                                        |
// | Purpose  : Shared constants and helpers for the 8-digit display scanner.   |
// |            N_DIG/IDX_W size the digit path; ANODE_OFF is the all-dark      |
// |            anode pattern; SEL_RST/IDX_RST are the reset select/index.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package scan_pkg;

    localparam int N_DIG = 8;
    localparam int IDX_W = 3;

    localparam logic [N_DIG-1:0] ANODE_OFF = 8'hFF;
    localparam logic [N_DIG-1:0] SEL_RST   = 8'h01;
    localparam logic [IDX_W-1:0] IDX_RST   = 3'd0;

    // One-hot select for a binary digit index.
    function automatic logic [N_DIG-1:0] idx_to_sel(input logic [IDX_W-1:0] i);
        return N_DIG'(1) << i;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_next_idx.sv
// +----------------------------------------------------------------------------+
// | Module   : scan_next_idx                                                   |
// | Purpose  : Combinational rotate-priority search. Finds the first set mask  |
// |            bit strictly after idx, wrapping 7->0; offset 8 is idx itself,  |
// |            so a lone set bit at idx returns idx.                           |
// | Ports    : idx      in  current digit index                                |
// |            mask     in  digit participation mask                           |
// |            next_idx out next participating digit (idx when none)           |
// |            found    out mask has at least one set bit                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module scan_next_idx
    import scan_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic [N_DIG-1:0] mask,
    output logic [IDX_W-1:0] next_idx,
    output logic             found
);

    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        next_idx = idx;
        w_pos    = idx;
        for (int k = N_DIG; k >= 1; k--) begin
            w_pos = idx + IDX_W'(k);
            if (mask[w_pos]) begin
                next_idx = w_pos;
            end
        end
    end

    assign found = |mask;

endmodule

`default_nettype wire

// File: rtl/scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : scan_ctrl                                                       |
// | Purpose  : Time-multiplexed 8-digit scanner. A prescaler of DIV cycles     |
// |            defines a slot; at each slot boundary the select rotates to the |
// |            next digit enabled in mask. Anodes are active-low, registered,  |
// |            and dark whenever en=0.                                         |
// | Config   : SCAN_DEADTIME_EN - when defined, anodes stay dark for the first |
// |            DEAD cycles of every slot (anti-ghosting). Undefined: no blank. |
// | Params   : DIV  cycles per slot (>=2); DEAD blank cycles (0 <= DEAD < DIV) |
// | Ports    : clk, rst_n (sync, active-low), en, mask[7:0]                   |
// |            sel[7:0] one-hot select, an[7:0] active-low anodes,             |
// |            idx[2:0] current digit, tick first-cycle-of-slot pulse          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIV  = 100000,
    parameter int DEAD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_DIG-1:0] mask,
    output logic [N_DIG-1:0] sel,
    output logic [N_DIG-1:0] an,
    output logic [IDX_W-1:0] idx,
    output logic             tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIV - 1);

`ifdef SCAN_DEADTIME_EN
    localparam bit c_dead_en = 1'b1;
`else
    localparam bit c_dead_en = 1'b0;
`endif

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [N_DIG-1:0] r_sel;
    logic [N_DIG-1:0] r_an;
    logic             r_tick;

    logic [IDX_W-1:0] w_search_idx;
    logic             w_found;
    logic             w_wrap;
    logic             w_adv;
    logic [CNT_W-1:0] w_cnt_next;
    logic [IDX_W-1:0] w_idx_next;
    logic [N_DIG-1:0] w_sel_next;
    logic             w_blank;
    logic [N_DIG-1:0] w_an_next;

    scan_next_idx u_next (
        .idx      (r_idx),
        .mask     (mask),
        .next_idx (w_search_idx),
        .found    (w_found)
    );

    // en gates the wrap, so a simultaneous en fall suppresses the advance.
    assign w_wrap     = en && (r_cnt == c_cnt_last);
    assign w_adv      = w_wrap && w_found;
    assign w_cnt_next = !en    ? r_cnt :
                        w_wrap ? '0    : r_cnt + 1'b1;
    assign w_idx_next = w_adv ? w_search_idx : r_idx;
    assign w_sel_next = idx_to_sel(w_idx_next);

    // Blanking is judged on the counter value that becomes current this edge,
    // so the tick cycle (cnt==0) is covered.
    assign w_blank   = c_dead_en && (int'(w_cnt_next) < DEAD);
    // Masking the select keeps a disabled digit dark even before the next
    // slot boundary moves the select away from it.
    assign w_an_next = (en && !w_blank) ? ~(w_sel_next & mask) : ANODE_OFF;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= IDX_RST;
            r_sel  <= SEL_RST;
            r_an   <= ANODE_OFF;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_idx  <= w_idx_next;
            r_sel  <= w_sel_next;
            r_an   <= w_an_next;
            r_tick <= w_adv;
        end
    end

    assign sel  = r_sel;
    assign an   = r_an;
    assign idx  = r_idx;
    assign tick = r_tick;

endmodule

`default_nettype wire
